// File: rtl/timing_gen.sv
// Master timing generator: clock-phase strobes, 7-stage Johnson bit-time
// counter, one-hot phase counter and HOLD/STEP control.
module timing_gen #(
    parameter int TPW = 8
) (
    input  logic CLK,
    input  logic RESET,
    input  logic HOLD,
    input  logic STEP,
    output logic V1,
    output logic V4MOD7,
    output logic W3,
    output logic X4,
    output logic Y1,
    output logic Y3,
    output logic Z5,
    output logic Z7,
    output logic XN,
    output logic ZN,
    output logic G1V,
    output logic G2V,
    output logic G3V,
    output logic G4V,
    output logic G5V,
    output logic G6V,
    output logic G7V,
    output logic G1VN,
    output logic G2VN,
    output logic G3VN,
    output logic G4VN,
    output logic G5VN,
    output logic G6VN,
    output logic G7VN,
    output logic PAV,
    output logic PBV,
    output logic PCV,
    output logic PAVN,
    output logic PBVN,
    output logic PCVN,
    output logic CYC_END,
    output logic HELD
);

    localparam int SW = $clog2(TPW);
    localparam logic [SW-1:0] SUB_LAST = SW'(TPW - 1);

    typedef enum logic [1:0] {S_RUN, S_HELD, S_STEP} state_t;

    state_t        state, state_n;
    logic [SW-1:0] sub, sub_n;   // tick within sub-phase window
    logic [2:0]    win, win_n;   // window V,W,X,Y,Z = 0..4
    logic [6:0]    g, g_n;       // g[0] = G1 .. g[6] = G7
    logic [2:0]    ph, ph_n;     // {PC,PB,PA} one-hot
    logic          last_sub, last_bt, last_ph, cyc_last, advance;

    // End-of-interval detection on the current counter position
    always_comb begin
        last_sub = (sub == SUB_LAST);
        last_bt  = last_sub && (win == 3'd4);
        last_ph  = last_bt && (g == 7'b1000000);
        cyc_last = last_ph && ph[2];
    end

    // Control FSM next state; counters move unless staying frozen in HELD
    always_comb begin
        state_n = state;
        case (state)
            S_RUN:   if (cyc_last && HOLD) state_n = S_HELD;
            S_HELD: begin
                if (!HOLD)     state_n = S_RUN;
                else if (STEP) state_n = S_STEP;
            end
            S_STEP:  if (cyc_last) state_n = HOLD ? S_HELD : S_RUN;
            default: state_n = S_RUN;
        endcase
        advance = (state != S_HELD) || (state_n != S_HELD);
    end

    // Next counter values
    always_comb begin
        sub_n = sub;
        win_n = win;
        g_n   = g;
        ph_n  = ph;
        if (advance) begin
            sub_n = last_sub ? '0 : sub + 1'b1;
            if (last_sub) win_n = (win == 3'd4) ? 3'd0 : win + 3'd1;
            if (last_bt)  g_n   = {g[5:0], ~g[6]};
            if (last_ph)  ph_n  = {ph[1:0], ph[2]};
        end
    end

    // State and counter registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= S_RUN;
            sub   <= '0;
            win   <= '0;
            g     <= '0;
            ph    <= 3'b001;
        end else begin
            state <= state_n;
            sub   <= sub_n;
            win   <= win_n;
            g     <= g_n;
            ph    <= ph_n;
        end
    end

    // Registered strobes decoded from the counter position being entered,
    // so each strobe is high in the same cycle the counter sits at its tick
    always_ff @(posedge CLK) begin
        if (RESET) begin
            {V1, V4MOD7, W3, X4, Y1, Y3, Z5, Z7} <= '0;
            XN      <= 1'b1;
            ZN      <= 1'b1;
            CYC_END <= 1'b0;
            HELD    <= 1'b0;
        end else begin
            V1      <= (win_n == 3'd0) && (sub_n == SW'(1));
            V4MOD7  <= (win_n == 3'd0) && (sub_n == SW'(4));
            W3      <= (win_n == 3'd1) && (sub_n == SW'(3));
            X4      <= (win_n == 3'd2) && (sub_n == SW'(4));
            Y1      <= (win_n == 3'd3) && (sub_n == SW'(1));
            Y3      <= (win_n == 3'd3) && (sub_n == SW'(3));
            Z5      <= (win_n == 3'd4) && (sub_n == SW'(5));
            Z7      <= (win_n == 3'd4) && (sub_n == SW'(7));
            XN      <= (win_n != 3'd2);
            ZN      <= (win_n != 3'd4);
            CYC_END <= (sub_n == SUB_LAST) && (win_n == 3'd4) &&
                       (g_n == 7'b1000000) && ph_n[2];
            HELD    <= (state_n == S_HELD);
        end
    end

    assign {G7V, G6V, G5V, G4V, G3V, G2V, G1V}        = g;
    assign {G7VN, G6VN, G5VN, G4VN, G3VN, G2VN, G1VN} = ~g;
    assign {PCV, PBV, PAV}                             = ph;
    assign {PCVN, PBVN, PAVN}                          = ~ph;

endmodule
